// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the FP add/sub back end.
// The mantissa bit positions describe the raw sum delivered by the align stage.
package fp_addsub_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [FP_EXP_W-1:0] EXP_MAX = '1;

  // Raw mantissa layout: {carry, hidden, frac[FP_MAN_W-1:0], G, R, S}
  localparam int CARRY_B  = FP_MAN_W + 4;
  localparam int HIDDEN_B = FP_MAN_W + 3;
  localparam int G_B      = 2;
  localparam int R_B      = 1;
  localparam int S_B      = 0;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a {hidden, frac} significand with guard/round/sticky bits.
// Purely combinational; the carry out marks a significand that rounded up to 2.0.
module fp_round_rne
  import fp_addsub_pkg::*;
#(
  parameter int MAN_WIDTH = FP_MAN_W
) (
  input  logic                 hidden_i,
  input  logic [MAN_WIDTH-1:0] frac_i,
  input  logic                 g_i,
  input  logic                 r_i,
  input  logic                 s_i,
  output logic [MAN_WIDTH:0]   man_rounded_o,
  output logic                 carry_out_o,
  output logic                 inexact_o
);

  logic                 up;
  logic [MAN_WIDTH+1:0] sum;

  // Ties (G=1, R=S=0) round up only when the kept LSB is odd.
  assign up            = g_i & (r_i | s_i | frac_i[0]);
  assign sum           = {1'b0, hidden_i, frac_i} + {{(MAN_WIDTH + 1){1'b0}}, up};
  assign man_rounded_o = sum[MAN_WIDTH:0];
  assign carry_out_o   = sum[MAN_WIDTH+1];
  assign inexact_o     = g_i | r_i | s_i;

endmodule

// File: rtl/fp_normalize_round.sv
// Normalise/round back end of the FP add/sub datapath: one normalisation shift per
// cycle, a single rounding cycle, then the packed result is held until taken.
module fp_normalize_round
  import fp_addsub_pkg::*;
#(
  parameter int EXP_WIDTH = FP_EXP_W,
  parameter int MAN_WIDTH = FP_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_WIDTH-1:0] in_exp,
  input  logic [MAN_WIDTH+4:0] in_man,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic [MAN_WIDTH-1:0] out_frac,
  output logic                 out_overflow,
  output logic                 out_inexact,
  output state_e               dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and a raised out_valid holds its data until accepted.

  state_e               state_q;
  logic                 sign_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [MAN_WIDTH+4:0] man_q;

  logic [EXP_WIDTH-1:0] exp_inc;
  logic [MAN_WIDTH:0]   rnd_man;
  logic                 rnd_carry;
  logic                 rnd_inexact;

  assign exp_inc     = exp_q + 1'b1;
  assign in_ready    = rst_n && (state_q == IDLE);
  assign dbg_state_o = state_q;

  fp_round_rne #(.MAN_WIDTH(MAN_WIDTH)) u_round (
    .hidden_i      (man_q[HIDDEN_B]),
    .frac_i        (man_q[HIDDEN_B-1:G_B+1]),
    .g_i           (man_q[G_B]),
    .r_i           (man_q[R_B]),
    .s_i           (man_q[S_B]),
    .man_rounded_o (rnd_man),
    .carry_out_o   (rnd_carry),
    .inexact_o     (rnd_inexact)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      man_q        <= '0;
      out_valid    <= 1'b0;
      out_sign     <= 1'b0;
      out_exp      <= '0;
      out_frac     <= '0;
      out_overflow <= 1'b0;
      out_inexact  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            exp_q   <= in_exp;
            man_q   <= in_man;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (exp_q == EXP_MAX) begin
            out_sign     <= sign_q;
            out_exp      <= EXP_MAX;
            out_frac     <= man_q[HIDDEN_B-1:G_B+1];
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
            out_valid    <= 1'b1;
            state_q      <= HOLD;
          end else if (man_q == '0) begin
            out_sign     <= 1'b0;
            out_exp      <= '0;
            out_frac     <= '0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
            out_valid    <= 1'b1;
            state_q      <= HOLD;
          end else if (man_q[CARRY_B]) begin
            // The bit shifted out of S folds back into the sticky position.
            man_q <= {1'b0, man_q[CARRY_B:2], man_q[1] | man_q[0]};
            exp_q <= exp_inc;
            if (exp_inc == EXP_MAX) begin
              out_sign     <= sign_q;
              out_exp      <= EXP_MAX;
              out_frac     <= '0;
              out_overflow <= 1'b1;
              out_inexact  <= 1'b1;
              out_valid    <= 1'b1;
              state_q      <= HOLD;
            end else begin
              state_q <= ROUND;
            end
          end else if (!man_q[HIDDEN_B] && (exp_q > EXP_WIDTH'(1))) begin
            man_q <= man_q << 1;
            exp_q <= exp_q - 1'b1;
          end else begin
            if (!man_q[HIDDEN_B]) exp_q <= '0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          out_sign    <= sign_q;
          out_inexact <= rnd_inexact;
          out_valid   <= 1'b1;
          state_q     <= HOLD;
          if (rnd_carry) begin
            out_frac     <= '0;
            out_exp      <= (exp_inc == EXP_MAX) ? EXP_MAX : exp_inc;
            out_overflow <= (exp_inc == EXP_MAX);
          end else begin
            // A subnormal that rounds up into the hidden bit becomes the smallest normal.
            out_exp      <= ((exp_q == '0) && rnd_man[MAN_WIDTH]) ? EXP_WIDTH'(1) : exp_q;
            out_frac     <= rnd_man[MAN_WIDTH-1:0];
            out_overflow <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed corner cases plus randomised operations
// checked against an arithmetic reference of normalise + round-to-nearest-even.
module tb_fp_normalize_round;
  import fp_addsub_pkg::*;

  localparam int RW = 34;  // {sign, exp[7:0], frac[22:0], overflow, inexact}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_man = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_sign, out_overflow, out_inexact;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  state_e      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];
  int            lat_q[$];

  fp_normalize_round dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_man       (in_man),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_exp      (out_exp),
    .out_frac     (out_frac),
    .out_overflow (out_overflow),
    .out_inexact  (out_inexact),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] observed();
    return {out_sign, out_exp, out_frac, out_overflow, out_inexact};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] ref_result(input logic s, input logic [7:0] e,
                                               input logic [27:0] m, output int lat);
    longint v, keep;
    int ee, lead, need, avail, k, rem;
    bit sub;
    logic ovf, inx;
    logic [7:0] oe;
    logic [22:0] of;
    sub = 0; ovf = 1'b0; inx = 1'b0; lat = 1;
    if (e == 8'hFF) return {s, 8'hFF, m[25:3], 2'b00};
    if (m == 28'd0) return {1'b0, 8'h00, 23'h0, 2'b00};
    v = longint'(m);
    ee = int'(e);
    if (m[27]) begin
      v = longint'(m >> 1) | longint'(m[0]);
      ee = ee + 1;
      if (ee == 255) return {s, 8'hFF, 23'h0, 2'b11};
      lat = 2;
    end else begin
      lead = 0;
      for (int i = 0; i < 27; i++) if (m[i]) lead = i;
      need  = 26 - lead;
      avail = (ee > 1) ? ee - 1 : 0;
      k     = (need < avail) ? need : avail;
      v     = v << k;
      ee    = ee - k;
      sub   = (need > avail);
      lat   = 2 + k;
    end
    keep = v >> 3;
    rem  = int'(v & 64'd7);
    if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep = keep + 1;
    inx = (rem != 0);
    if (sub) begin
      oe = (keep >= (64'd1 << 23)) ? 8'd1 : 8'd0;
      of = keep[22:0];
    end else if (keep == (64'd1 << 24)) begin
      ee  = ee + 1;
      of  = 23'h0;
      ovf = (ee == 255);
      oe  = ee[7:0];
    end else begin
      oe = ee[7:0];
      of = keep[22:0];
    end
    return {s, oe, of, ovf, inx};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic s, input logic [7:0] e, input logic [27:0] m);
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    n_vec++;
    if ({out_valid, observed()} !== 35'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", {out_valid, observed()});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [27:0]   man_t[7];
    logic [7:0]    exp_t[7];
    logic          sgn_t[7];
    logic [RW-1:0] res_t[7];
    int            lat_t[7];
    int            lat;
    man_t = '{28'h8000000, 28'h0000008, 28'h0000000, 28'h400000C, 28'h4000004,
              28'h8000000, 28'h0000000};
    exp_t = '{8'h80, 8'h85, 8'h40, 8'h7F, 8'h7F, 8'hFE, 8'hFF};
    sgn_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    res_t = '{{1'b0, 8'h81, 23'h0, 2'b00}, {1'b0, 8'h6E, 23'h0, 2'b00},
              {1'b0, 8'h00, 23'h0, 2'b00}, {1'b0, 8'h7F, 23'h2, 2'b01},
              {1'b0, 8'h7F, 23'h0, 2'b01}, {1'b0, 8'hFF, 23'h0, 2'b11},
              {1'b1, 8'hFF, 23'h0, 2'b00}};
    lat_t = '{2, 25, 1, 2, 2, 1, 1};
    for (int i = 0; i < 7; i++) begin
      drive_op(sgn_t[i], exp_t[i], man_t[i]);
      wait_result(lat);
      n_vec++;
      if (lat !== lat_t[i]) begin
        n_err++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, lat_t[i]);
      end
      n_vec++;
      if (observed() !== res_t[i]) begin
        n_err++; $display("FAIL directed_result[%0d]: got %h expected %h", i, observed(), res_t[i]);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] snap;
    int lat;
    int bad;
    drive_op(1'b1, 8'h7F, 28'h400000C);
    wait_result(lat);
    snap = observed();
    n_vec++;
    if (snap !== {1'b1, 8'h7F, 23'h2, 2'b01}) begin
      n_err++; $display("FAIL bp_result: got %h expected %h", snap, {1'b1, 8'h7F, 23'h2, 2'b01});
    end
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || observed() !== snap || in_ready !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", bad);
    end
    // Offer a new operation in the same cycle the result is taken; it must not be accepted.
    in_sign = 1'b0; in_exp = 8'h80; in_man = 28'h8000000; in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL bp_release: got valid/ready %b expected 01", {out_valid, in_ready});
    end
    in_valid = 1'b0;
    bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL bp_no_double_accept: got %0d valid cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_op();
    int bad;
    drive_op(1'b0, 8'h85, 28'h0000008);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b00) begin
      n_err++; $display("FAIL midrst_during: got valid/ready %b expected 00", {out_valid, in_ready});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_ready: got %b expected 1", in_ready);
    end
    bad = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL midrst_no_output: got %0d valid cycles expected 0", bad);
    end
  endtask

  task automatic test_random(input int n);
    logic          s;
    logic [7:0]    e;
    logic [27:0]   m;
    logic [RW-1:0] expv;
    int            lat, elat, cat, ec, p;
    for (int i = 0; i < n; i++) begin
      cat = $urandom_range(0, 9);
      s   = 1'($urandom);
      if (cat == 0) begin
        m = 28'd0;
      end else if (cat == 1) begin
        m = {2'b01, 23'h7FFFFF, 3'($urandom_range(4, 7))};
      end else begin
        p = $urandom_range(0, 27);
        m = (28'd1 << p) | (28'($urandom) & ((28'd1 << p) - 28'd1));
      end
      ec = $urandom_range(0, 9);
      if (ec == 0)      e = 8'hFF;
      else if (ec == 1) e = 8'hFE;
      else if (ec == 2) e = 8'($urandom_range(1, 4));
      else              e = 8'($urandom_range(1, 254));
      exp_q.push_back(ref_result(s, e, m, elat));
      lat_q.push_back(elat);
      drive_op(s, e, m);
      wait_result(lat);
      expv = exp_q.pop_front();
      elat = lat_q.pop_front();
      n_vec++;
      if (lat !== elat || observed() !== expv) begin
        n_err++;
        $display("FAIL random[%0d] e=%h m=%h: got %h lat %0d expected %h lat %0d",
                 i, e, m, observed(), lat, expv, elat);
      end
      release_result();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random(200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
